// File: rtl/video_pkg.sv
// Shared level constants, default timing and decoder state type for the
// composite playback decoder (optional DECODE_STATS_EN lives in the top).
package video_pkg;

    localparam logic [7:0] BLANK      = 8'd41;
    localparam logic [7:0] START_MARK = 8'd180;
    localparam logic [7:0] END_MARK   = 8'd200;
    localparam logic [7:0] DIS_START  = 8'd42;
    localparam logic [7:0] DIS_END    = 8'd49;

    localparam int HS_MIN_DEF   = 20;
    localparam int HS_MAX_DEF   = 40;
    localparam int VS_MIN_DEF   = 100;
    localparam int MARK_OFS_DEF = 28;
    localparam int MARK_WIN_DEF = 4;
    localparam int DATA_LEN_DEF = 331;
    localparam int START_TH_DEF = 150;
    localparam int END_TH_DEF   = 190;

    typedef enum logic [2:0] {
        IDLE,
        SYNC_LOW,
        SEARCH,
        DATA,
        CHECK
    } dec_state_t;

endpackage

// File: rtl/sync_pulse_classifier.sv
// Measures each sync-low run and flags it on the rising edge of sync as an
// hsync-width or broad (vsync serration) pulse.
module sync_pulse_classifier
    import video_pkg::*;
#(
    parameter int HS_MIN = HS_MIN_DEF,
    parameter int HS_MAX = HS_MAX_DEF,
    parameter int VS_MIN = VS_MIN_DEF
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sync,
    output logic o_is_hsync,
    output logic o_is_broad
);

    localparam logic [7:0] L_HS_MIN = 8'(HS_MIN);
    localparam logic [7:0] L_HS_MAX = 8'(HS_MAX);
    localparam logic [7:0] L_VS_MIN = 8'(VS_MIN);

    logic [7:0] r_width;
    logic       w_rise;

    // Width holds at 255 so very long broad pulses still classify as broad.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_width <= '0;
        end else if (!i_sync) begin
            if (r_width != 8'hFF) begin
                r_width <= r_width + 8'd1;
            end
        end else begin
            r_width <= '0;
        end
    end

    assign w_rise     = i_sync && (r_width != 8'd0);
    assign o_is_hsync = w_rise && (r_width >= L_HS_MIN) && (r_width <= L_HS_MAX);
    assign o_is_broad = w_rise && (r_width >= L_VS_MIN);

endmodule

// File: rtl/video_in_decoder.sv
// Line-locked payload recovery from replayed composite video.
// Define DECODE_STATS_EN to add the good_lines/bad_lines status counters.
module video_in_decoder
    import video_pkg::*;
#(
    parameter int HS_MIN   = HS_MIN_DEF,
    parameter int HS_MAX   = HS_MAX_DEF,
    parameter int VS_MIN   = VS_MIN_DEF,
    parameter int MARK_OFS = MARK_OFS_DEF,
    parameter int MARK_WIN = MARK_WIN_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int START_TH = START_TH_DEF,
    parameter int END_TH   = END_TH_DEF
)(
    input  logic        clkin,
    input  logic        rst,
    input  logic [7:0]  video_in,
    input  logic        sync_in,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_first,
    output logic        line_done,
    output logic        line_ok,
    output logic        field_start
`ifdef DECODE_STATS_EN
    ,
    output logic [15:0] good_lines,
    output logic [15:0] bad_lines
`endif
);

    localparam logic [8:0] L_WIN_LO   = 9'(MARK_OFS - MARK_WIN);
    localparam logic [8:0] L_WIN_HI   = 9'(MARK_OFS + MARK_WIN);
    localparam logic [8:0] L_LAST_IDX = 9'(DATA_LEN - 1);
    localparam logic [7:0] L_START_TH = 8'(START_TH);
    localparam logic [7:0] L_END_TH   = 8'(END_TH);

    dec_state_t r_state;
    dec_state_t w_next_state;
    logic [8:0] r_offset;
    logic [8:0] r_idx;
    logic       r_in_vsync;
    logic [8:0] w_sample_ofs;
    logic       w_is_hsync;
    logic       w_is_broad;
    logic       w_rise;
    logic       w_hit;
    logic       w_timeout;
    logic       w_emit;
    logic       w_done;
    logic       w_ok;
    logic       w_fs;

    sync_pulse_classifier #(
        .HS_MIN (HS_MIN),
        .HS_MAX (HS_MAX),
        .VS_MIN (VS_MIN)
    ) u_classifier (
        .i_clk      (clkin),
        .i_rst      (rst),
        .i_sync     (sync_in),
        .o_is_hsync (w_is_hsync),
        .o_is_broad (w_is_broad)
    );

    // r_offset counts SEARCH cycles; the rise cycle itself is offset 0.
    assign w_sample_ofs = r_offset + 9'd1;
    assign w_rise       = (r_state == SYNC_LOW) && sync_in;
    assign w_hit        = (w_sample_ofs >= L_WIN_LO) && (w_sample_ofs <= L_WIN_HI)
                          && (video_in >= L_START_TH);
    assign w_timeout    = (w_sample_ofs >= L_WIN_HI);

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (!sync_in) w_next_state = SYNC_LOW;
            SYNC_LOW: if (sync_in)  w_next_state = w_is_hsync ? SEARCH : IDLE;
            SEARCH: begin
                if (!sync_in)       w_next_state = SYNC_LOW;
                else if (w_hit)     w_next_state = DATA;
                else if (w_timeout) w_next_state = IDLE;
            end
            DATA: begin
                if (!sync_in)                  w_next_state = SYNC_LOW;
                else if (r_idx == L_LAST_IDX)  w_next_state = CHECK;
            end
            CHECK:    w_next_state = sync_in ? IDLE : SYNC_LOW;
            default:  w_next_state = IDLE;
        endcase
    end

    // Sync dropping inside DATA/CHECK ends the line as a failure.
    always_comb begin
        w_emit = 1'b0;
        w_done = 1'b0;
        w_ok   = 1'b0;
        w_fs   = 1'b0;
        case (r_state)
            SYNC_LOW: w_fs = w_rise && w_is_broad && !r_in_vsync;
            DATA: begin
                w_emit = sync_in;
                w_done = !sync_in;
            end
            CHECK: begin
                w_done = 1'b1;
                w_ok   = sync_in && (video_in >= L_END_TH);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_first   <= 1'b0;
            line_done   <= 1'b0;
            line_ok     <= 1'b0;
            field_start <= 1'b0;
            r_offset    <= '0;
            r_idx       <= '0;
            r_in_vsync  <= 1'b0;
        end else begin
            out_valid   <= w_emit;
            out_first   <= w_emit && (r_idx == 9'd0);
            line_done   <= w_done;
            field_start <= w_fs;
            if (w_emit) begin
                out_data <= video_in;
            end
            if (w_done) begin
                line_ok <= w_ok;
            end
            if (w_rise && w_is_hsync) begin
                r_offset <= '0;
            end else if (r_state == SEARCH) begin
                r_offset <= r_offset + 9'd1;
            end
            if (r_state == SEARCH) begin
                r_idx <= '0;
            end else if (w_emit) begin
                r_idx <= r_idx + 9'd1;
            end
            if (w_rise && w_is_hsync) begin
                r_in_vsync <= 1'b0;
            end else if (w_rise && w_is_broad) begin
                r_in_vsync <= 1'b1;
            end
        end
    end

`ifdef DECODE_STATS_EN
    always_ff @(posedge clkin) begin
        if (rst) begin
            good_lines <= '0;
            bad_lines  <= '0;
        end else if (w_done) begin
            if (w_ok) begin
                good_lines <= good_lines + 16'd1;
            end else begin
                bad_lines <= bad_lines + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_video_in_decoder.sv
// Directed bench for video_in_decoder: line/pulse generators feed a line-level
// expectation model; one negedge process compares every output cycle.
module tb_video_in_decoder;
    import video_pkg::*;

    logic        clkin    = 1'b0;
    logic        rst      = 1'b1;
    logic [7:0]  video_in = BLANK;
    logic        sync_in  = 1'b1;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_first;
    logic        line_done;
    logic        line_ok;
    logic        field_start;
`ifdef DECODE_STATS_EN
    logic [15:0] good_lines;
    logic [15:0] bad_lines;
`endif

    always #5 clkin = ~clkin;

    video_in_decoder dut (
        .clkin       (clkin),
        .rst         (rst),
        .video_in    (video_in),
        .sync_in     (sync_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_first   (out_first),
        .line_done   (line_done),
        .line_ok     (line_ok),
        .field_start (field_start)
`ifdef DECODE_STATS_EN
        ,
        .good_lines  (good_lines),
        .bad_lines   (bad_lines)
`endif
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_byte[$];
    bit         exp_first[$];
    bit         exp_ok[$];
    logic [7:0] m_last_byte = 8'd0;
    bit         m_ok        = 1'b0;
    bit         m_in_vsync  = 1'b0;
    int         m_good      = 0;
    int         m_bad       = 0;
    int         m_fs        = 0;
    int         n_valid     = 0;
    int         n_done      = 0;
    int         n_fs        = 0;
    logic       rst_q       = 1'b1;
    logic [7:0] e_b;
    bit         e_f;
    bit         e_ok;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // rst as the DUT saw it on the last rising edge
    always @(posedge clkin) rst_q <= rst;

    always @(negedge clkin) begin
        if (rst_q) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_line_done", line_done, 0);
            chk("rst_line_ok", line_ok, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_field_start", field_start, 0);
            m_last_byte = 8'd0;
            m_ok        = 1'b0;
            m_good      = 0;
            m_bad       = 0;
        end else begin
            if (out_valid) begin
                n_valid++;
                if (exp_byte.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    e_b = exp_byte.pop_front();
                    e_f = exp_first.pop_front();
                    chk("out_data", out_data, e_b);
                    chk("out_first", out_first, e_f);
                    m_last_byte = e_b;
                end
            end else begin
                chk("out_data_hold", out_data, m_last_byte);
                chk("out_first_idle", out_first, 0);
            end
            if (line_done) begin
                n_done++;
                if (exp_ok.size() == 0) begin
                    chk("unexpected_line_done", line_done, 0);
                end else begin
                    e_ok = exp_ok.pop_front();
                    chk("line_ok", line_ok, e_ok);
                    m_ok = e_ok;
                    if (e_ok) m_good++;
                    else m_bad++;
                end
            end else begin
                chk("line_ok_hold", line_ok, m_ok);
            end
            if (field_start) n_fs++;
`ifdef DECODE_STATS_EN
            chk("good_lines", good_lines, m_good);
            chk("bad_lines", bad_lines, m_bad);
`endif
        end
    end

    task automatic drive(input logic s, input logic [7:0] v);
        @(posedge clkin);
        #2;
        sync_in  = s;
        video_in = v;
    endtask

    // Pulse classification from its low width; returns 1 for an hsync.
    function automatic bit model_pulse(input int w);
        bit hs;
        hs = (w >= 20) && (w <= 40);
        if (hs) begin
            m_in_vsync = 1'b0;
        end else if (w >= 100) begin
            if (!m_in_vsync) m_fs++;
            m_in_vsync = 1'b1;
        end
        return hs;
    endfunction

    task automatic send_pulse(input int w, input int h);
        void'(model_pulse(w));
        for (int i = 0; i < w; i++) drive(1'b0, 8'd0);
        for (int i = 0; i < h; i++) drive(1'b1, BLANK);
    endtask

    // Line: sync low sync_w, then samples indexed by offset from the sync rise.
    // stop_at >= 0 cuts the line at that payload byte (sync drop or reset).
    task automatic send_line(input int sync_w, input int mark_ofs, input logic [7:0] mark_val,
                             input logic [7:0] end_val, input int stop_at, input int pat,
                             input bit by_reset);
        logic [7:0] s[$];
        int         hi_len;
        int         k;
        bit         hs;
        bit         cut;
        for (int o = 0; o < mark_ofs; o++) s.push_back(BLANK);
        s.push_back(mark_val);
        for (int i = 0; i < 331; i++) s.push_back((pat == 0) ? 8'(i) : 8'(i * 7 + 3));
        s.push_back(end_val);
        for (int i = 0; i < 8; i++) s.push_back(BLANK);
        hi_len = (stop_at >= 0) ? (mark_ofs + 1 + stop_at) : s.size();

        hs = model_pulse(sync_w);
        k  = -1;
        if (hs) begin
            for (int o = 24; o <= 32; o++) begin
                if (k < 0 && o < hi_len && s[o] >= 8'd150) k = o;
            end
        end
        if (k >= 0) begin
            cut = 1'b0;
            for (int i = 0; i < 331; i++) begin
                if (!cut && (k + 1 + i) < hi_len) begin
                    exp_byte.push_back(s[k + 1 + i]);
                    exp_first.push_back(i == 0);
                end else begin
                    cut = 1'b1;
                end
            end
            if (!by_reset) begin
                if (cut || (k + 332) >= hi_len) exp_ok.push_back(1'b0);
                else exp_ok.push_back(s[k + 332] >= 8'd190);
            end
        end

        for (int i = 0; i < sync_w; i++) drive(1'b0, 8'd0);
        for (int o = 0; o < hi_len; o++) drive(1'b1, s[o]);
        if (by_reset) begin
            @(posedge clkin);
            #2;
            rst        = 1'b1;
            sync_in    = 1'b1;
            video_in   = BLANK;
            m_in_vsync = 1'b0;
            repeat (2) @(posedge clkin);
            #2;
            rst = 1'b0;
        end
    endtask

    int v0, d0, f0;

    initial begin
        repeat (3) @(posedge clkin);
        #2;
        rst = 1'b0;
        @(negedge clkin);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_first", out_first, 0);
        chk("reset_line_done", line_done, 0);
        chk("reset_line_ok", line_ok, 0);
        chk("reset_field_start", field_start, 0);
        chk("reset_out_data", out_data, 0);

        // reset during byte 50 of a good line: 50 bytes, no line_done
        v0 = n_valid; d0 = n_done;
        send_line(29, 28, START_MARK, END_MARK, 50, 1, 1'b1);
        chk("rst_mid_valid_count", n_valid - v0, 50);
        chk("rst_mid_done_count", n_done - d0, 0);

        v0 = n_valid; d0 = n_done;
        send_line(29, 28, START_MARK, END_MARK, -1, 0, 1'b0);
        chk("t1_valid_count", n_valid - v0, 331);
        chk("t1_done_count", n_done - d0, 1);
        chk("t1_last_byte", out_data, 74);
        chk("t1_line_ok", line_ok, 1);

        v0 = n_valid; d0 = n_done;
        send_line(29, 28, DIS_START, DIS_END, -1, 1, 1'b0);
        chk("t2_valid_count", n_valid - v0, 0);
        chk("t2_done_count", n_done - d0, 0);

        v0 = n_valid; d0 = n_done;
        send_line(29, 32, START_MARK, END_MARK, -1, 1, 1'b0);
        chk("t3_ofs32_valid_count", n_valid - v0, 331);
        chk("t3_ofs32_done_count", n_done - d0, 1);
        v0 = n_valid; d0 = n_done;
        send_line(29, 33, START_MARK, END_MARK, -1, 1, 1'b0);
        chk("t3_ofs33_valid_count", n_valid - v0, 0);
        chk("t3_ofs33_done_count", n_done - d0, 0);

        v0 = n_valid; d0 = n_done;
        send_line(29, 28, START_MARK, DIS_END, -1, 1, 1'b0);
        chk("t4_valid_count", n_valid - v0, 331);
        chk("t4_done_count", n_done - d0, 1);
        chk("t4_line_ok", line_ok, 0);

        v0 = n_valid; d0 = n_done; f0 = n_fs;
        for (int i = 0; i < 6; i++) send_pulse(13, 20);
        for (int i = 0; i < 6; i++) send_pulse(170, 20);
        for (int i = 0; i < 6; i++) send_pulse(13, 20);
        chk("t5_field_start_count", n_fs - f0, 1);
        chk("t5_valid_count", n_valid - v0, 0);
        chk("t5_done_count", n_done - d0, 0);

        v0 = n_valid; d0 = n_done;
        send_line(29, 28, START_MARK, END_MARK, 100, 1, 1'b0);
        send_line(29, 28, START_MARK, END_MARK, -1, 0, 1'b0);
        chk("t6_valid_count", n_valid - v0, 431);
        chk("t6_done_count", n_done - d0, 2);
        chk("t6_line_ok", line_ok, 1);

        repeat (4) drive(1'b1, BLANK);
        chk("pending_bytes", exp_byte.size(), 0);
        chk("pending_line_done", exp_ok.size(), 0);
        chk("field_start_total", n_fs, m_fs);
`ifdef DECODE_STATS_EN
        chk("stats_good_total", good_lines, 3);
        chk("stats_bad_total", bad_lines, 2);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
